// File: rtl/audio_pkg.sv
// Shared widths, divider constants, mixer state encoding and the saturation
// helper used by the audio mixer and its I2S transmitter.
package audio_pkg;

  localparam int NUM_CH_DEF    = 4;
  localparam int SAMPLE_W_DEF  = 16;
  localparam int GAIN_W_DEF    = 4;
  localparam int MCLK_LOG2_DEF = 2;
  localparam int SCK_LOG2_DEF  = 4;
  localparam int LRCK_LOG2_DEF = 9;

  // Mixer sequencing: wait for the frame start, walk the voices, clamp once.
  typedef enum logic [1:0] {
    MIX_IDLE = 2'd0,
    MIX_ACC  = 2'd1,
    MIX_SAT  = 2'd2
  } mix_state_e;

  // Clamp a signed value into the range of a signed word of 'width' bits.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (value > max_v) begin
      return max_v;
    end
    if (value < min_v) begin
      return min_v;
    end
    return value;
  endfunction

endpackage

// File: rtl/i2s_tx.sv
// I2S transmitter: free-running frame divider, frame-start pulse, frame latch
// of the pending stereo words and the MSB-first serial shifter with the
// standard one-bit-clock delay after the LR clock edge.
module i2s_tx
  import audio_pkg::*;
#(
  parameter int SAMPLE_W  = SAMPLE_W_DEF,
  parameter int MCLK_LOG2 = MCLK_LOG2_DEF,
  parameter int SCK_LOG2  = SCK_LOG2_DEF,
  parameter int LRCK_LOG2 = LRCK_LOG2_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] pend_l,
  input  logic [SAMPLE_W-1:0] pend_r,
  input  logic                pend_clip,
  output logic                sample_req,
  output logic                clip_flag,
  output logic                mclk,
  output logic                lrck,
  output logic                sck,
  output logic                sdin
);

  localparam int SLOT_W = LRCK_LOG2 - SCK_LOG2;
  localparam int BIT_W  = $clog2(SAMPLE_W);

  logic [LRCK_LOG2-1:0] div_cnt;
  logic [SAMPLE_W-1:0]  tx_l;
  logic [SAMPLE_W-1:0]  tx_r;
  logic [SLOT_W-1:0]    next_slot;
  logic [BIT_W-1:0]     bit_idx;
  logic                 next_bit;
  logic                 frame_end;
  logic                 sck_fall;

  // All audio clocks are plain divider bits, so they come straight off flops.
  assign mclk = div_cnt[MCLK_LOG2-1];
  assign sck  = div_cnt[SCK_LOG2-1];
  assign lrck = div_cnt[LRCK_LOG2-1];

  // Frame-start pulse: upstream voices advance by one sample per pulse.
  assign sample_req = rst && (div_cnt == '0);

  assign frame_end = &div_cnt;
  assign sck_fall  = &div_cnt[SCK_LOG2-1:0];
  assign next_slot = div_cnt[LRCK_LOG2-1:SCK_LOG2] + SLOT_W'(1);

  // Bit for the slot about to start. Slots 1..SAMPLE_W carry the left word
  // MSB first, the rest carry the right word; slot 0 still holds the LSB of
  // the outgoing right word because the latch happens on the same edge.
  // Negating the slot number gives the bit position in both halves.
  always_comb begin
    bit_idx = BIT_W'(SLOT_W'(0) - next_slot);
    if ((next_slot != '0) && (next_slot <= SLOT_W'(SAMPLE_W))) begin
      next_bit = tx_l[bit_idx];
    end else begin
      next_bit = tx_r[bit_idx];
    end
  end

  // Free-running frame divider.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + LRCK_LOG2'(1);
    end
  end

  // Frame latch: words and clip status change only at the frame boundary.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_l      <= '0;
      tx_r      <= '0;
      clip_flag <= 1'b0;
    end else if (frame_end) begin
      tx_l      <= pend_l;
      tx_r      <= pend_r;
      clip_flag <= pend_clip;
    end
  end

  // Serial data changes only on the falling edge of the bit clock.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sdin <= 1'b0;
    end else if (sck_fall) begin
      sdin <= next_bit;
    end
  end

endmodule

// File: rtl/audio_mixer_i2s.sv
// Multi-voice mixer feeding an I2S DAC. Each frame the voices are walked one
// per cycle, scaled by their gain, summed into left/right accumulators
// according to routing, shifted back to unity, clamped and handed to the
// transmitter, which sends them in the following frame.
// Pacing: sample_req is a one-cycle pulse at frame start; there is no
// back-pressure, upstream must hold each voice stable until it is captured.
module audio_mixer_i2s
  import audio_pkg::*;
#(
  parameter int NUM_CH    = NUM_CH_DEF,
  parameter int SAMPLE_W  = SAMPLE_W_DEF,
  parameter int GAIN_W    = GAIN_W_DEF,
  parameter int MCLK_LOG2 = MCLK_LOG2_DEF,
  parameter int SCK_LOG2  = SCK_LOG2_DEF,
  parameter int LRCK_LOG2 = LRCK_LOG2_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH*SAMPLE_W-1:0] ch_sample,
  input  logic [NUM_CH-1:0]          ch_valid,
  input  logic [NUM_CH*GAIN_W-1:0]   ch_gain,
  input  logic [2*NUM_CH-1:0]        ch_route,
  input  logic                       master_mute,
  output logic                       sample_req,
  output logic                       clip_flag,
  output logic                       audio_mclk,
  output logic                       audio_lrck,
  output logic                       audio_sck,
  output logic                       audio_sdin
);

  localparam int PROD_W = SAMPLE_W + GAIN_W + 1;
  localparam int ACC_W  = PROD_W + $clog2(NUM_CH);
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // Elaboration-time guards on the parameter set.
  if ((NUM_CH < 1) || (NUM_CH > 8)) begin : g_bad_num_ch
    $error("audio_mixer_i2s: NUM_CH must be 1..8");
  end
  if (SAMPLE_W != 2 ** (LRCK_LOG2 - SCK_LOG2 - 1)) begin : g_bad_sample_w
    $error("audio_mixer_i2s: SAMPLE_W must fill one half frame of bit clocks");
  end
  if (NUM_CH + 2 >= 2 ** LRCK_LOG2) begin : g_bad_frame
    $error("audio_mixer_i2s: mixing does not fit in one frame");
  end

  mix_state_e                  mix_state;
  logic [IDX_W-1:0]            ch_idx;
  logic signed [ACC_W-1:0]     acc_l;
  logic signed [ACC_W-1:0]     acc_r;
  logic signed [ACC_W-1:0]     mix_l;
  logic signed [ACC_W-1:0]     mix_r;
  logic                        clip_l;
  logic                        clip_r;
  logic signed [PROD_W-1:0]    prod;
  logic [SAMPLE_W-1:0]         pend_l;
  logic [SAMPLE_W-1:0]         pend_r;
  logic                        pend_clip;

  logic signed [SAMPLE_W-1:0]  smp   [NUM_CH];
  logic [GAIN_W-1:0]           gain  [NUM_CH];
  logic                        use_l [NUM_CH];
  logic                        use_r [NUM_CH];

  // Per-voice views of the flat input buses.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
    assign smp[k]   = ch_sample[k*SAMPLE_W +: SAMPLE_W];
    assign gain[k]  = ch_gain[k*GAIN_W +: GAIN_W];
    assign use_l[k] = ch_valid[k] & ch_route[2*k];
    assign use_r[k] = ch_valid[k] & ch_route[2*k+1];
  end

  // Scaled contribution of the voice selected this cycle (signed x unsigned).
  always_comb begin
    prod = $signed(PROD_W'(smp[ch_idx])) * $signed(PROD_W'(gain[ch_idx]));
  end

  // Undo the unity gain scaling and detect words that need clamping.
  always_comb begin
    mix_l  = acc_l >>> (GAIN_W - 1);
    mix_r  = acc_r >>> (GAIN_W - 1);
    clip_l = (sat_signed(64'(mix_l), SAMPLE_W) != 64'(mix_l));
    clip_r = (sat_signed(64'(mix_r), SAMPLE_W) != 64'(mix_r));
  end

  // Mixer sequencer: accumulate one voice per cycle, then clamp into pending.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mix_state <= MIX_IDLE;
      ch_idx    <= '0;
      acc_l     <= '0;
      acc_r     <= '0;
      pend_l    <= '0;
      pend_r    <= '0;
      pend_clip <= 1'b0;
    end else begin
      case (mix_state)
        MIX_IDLE: begin
          if (sample_req) begin
            mix_state <= MIX_ACC;
            ch_idx    <= '0;
            acc_l     <= '0;
            acc_r     <= '0;
          end
        end
        MIX_ACC: begin
          if (use_l[ch_idx]) begin
            acc_l <= acc_l + ACC_W'(prod);
          end
          if (use_r[ch_idx]) begin
            acc_r <= acc_r + ACC_W'(prod);
          end
          if (ch_idx == IDX_W'(NUM_CH - 1)) begin
            mix_state <= MIX_SAT;
          end else begin
            ch_idx <= ch_idx + IDX_W'(1);
          end
        end
        MIX_SAT: begin
          mix_state <= MIX_IDLE;
          if (master_mute) begin
            pend_l    <= '0;
            pend_r    <= '0;
            pend_clip <= 1'b0;
          end else begin
            pend_l    <= SAMPLE_W'(sat_signed(64'(mix_l), SAMPLE_W));
            pend_r    <= SAMPLE_W'(sat_signed(64'(mix_r), SAMPLE_W));
            pend_clip <= clip_l | clip_r;
          end
        end
        default: begin
          mix_state <= MIX_IDLE;
        end
      endcase
    end
  end

  i2s_tx #(
    .SAMPLE_W  (SAMPLE_W),
    .MCLK_LOG2 (MCLK_LOG2),
    .SCK_LOG2  (SCK_LOG2),
    .LRCK_LOG2 (LRCK_LOG2)
  ) u_i2s_tx (
    .clk        (clk),
    .rst        (rst),
    .pend_l     (pend_l),
    .pend_r     (pend_r),
    .pend_clip  (pend_clip),
    .sample_req (sample_req),
    .clip_flag  (clip_flag),
    .mclk       (audio_mclk),
    .lrck       (audio_lrck),
    .sck        (audio_sck),
    .sdin       (audio_sdin)
  );

endmodule

// File: tb/tb_audio_mixer_i2s.sv
// Bench for the I2S audio mixer (8-voice build). A behavioural model computes
// each frame's stereo words from the voice inputs with plain integer
// arithmetic; the serial stream, audio clocks, sample_req and clip_flag are
// compared frame by frame, with directed cases followed by random frames.
module tb_audio_mixer_i2s;

  localparam int NUM_CH = 8;
  localparam int SW     = 16;
  localparam int GW     = 4;
  localparam int FRAME  = 512;

  // Clock / reset.
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_CH*SW-1:0] ch_sample;
  logic [NUM_CH-1:0]    ch_valid;
  logic [NUM_CH*GW-1:0] ch_gain;
  logic [2*NUM_CH-1:0]  ch_route;
  logic                 master_mute;
  logic                 sample_req;
  logic                 clip_flag;
  logic                 audio_mclk;
  logic                 audio_lrck;
  logic                 audio_sck;
  logic                 audio_sdin;

  audio_mixer_i2s #(
    .NUM_CH (NUM_CH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ch_sample   (ch_sample),
    .ch_valid    (ch_valid),
    .ch_gain     (ch_gain),
    .ch_route    (ch_route),
    .master_mute (master_mute),
    .sample_req  (sample_req),
    .clip_flag   (clip_flag),
    .audio_mclk  (audio_mclk),
    .audio_lrck  (audio_lrck),
    .audio_sck   (audio_sck),
    .audio_sdin  (audio_sdin)
  );

  // Scoreboard: {clip, left, right} expected for each upcoming frame.
  logic [32:0] exp_q[$];
  logic        prev_r0;
  logic [31:0] last_obs;
  logic        last_clip;
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model.
  function automatic longint floor_div8(input longint a);
    if (a >= 0) return a / 8;
    return -((-a + 7) / 8);
  endfunction

  function automatic logic [32:0] model_frame();
    longint      acc_l;
    longint      acc_r;
    longint      s;
    longint      g;
    longint      ml;
    longint      mr;
    logic [15:0] raw;
    logic        cl;
    acc_l = 0;
    acc_r = 0;
    cl    = 1'b0;
    if (master_mute) return '0;
    for (int k = 0; k < NUM_CH; k++) begin
      raw = ch_sample[k*SW +: SW];
      s   = longint'($signed(raw));
      g   = longint'(ch_gain[k*GW +: GW]);
      if (ch_valid[k]) begin
        if (ch_route[2*k])   acc_l += s * g;
        if (ch_route[2*k+1]) acc_r += s * g;
      end
    end
    ml = floor_div8(acc_l);
    mr = floor_div8(acc_r);
    if (ml > 32767)  begin ml = 32767;  cl = 1'b1; end
    if (ml < -32768) begin ml = -32768; cl = 1'b1; end
    if (mr > 32767)  begin mr = 32767;  cl = 1'b1; end
    if (mr < -32768) begin mr = -32768; cl = 1'b1; end
    return {cl, 16'(ml), 16'(mr)};
  endfunction

  // Driver tasks.
  task automatic clear_inputs();
    ch_sample   = '0;
    ch_valid    = '0;
    ch_gain     = '0;
    ch_route    = '0;
    master_mute = 1'b0;
  endtask

  task automatic set_voice(input int k, input logic [15:0] smp, input logic v,
                           input logic [3:0] g, input logic [1:0] rt);
    ch_sample[k*SW +: SW] = smp;
    ch_valid[k]           = v;
    ch_gain[k*GW +: GW]   = g;
    ch_route[2*k +: 2]    = rt;
  endtask

  task automatic randomize_inputs();
    for (int k = 0; k < NUM_CH; k++) begin
      set_voice(k, 16'($urandom), 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
    end
    master_mute = ($urandom_range(0, 7) == 0);
  endtask

  // Hold reset for n cycles from the next falling edge, checking outputs stay
  // low, then release just after a rising edge so the next cycle is frame start.
  task automatic apply_reset(input int n);
    int nz;
    nz = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if ({sample_req, clip_flag, audio_mclk, audio_lrck, audio_sck, audio_sdin} !== 6'b0) nz++;
    end
    @(posedge clk);
    #1 rst = 1'b1;
    check("reset_outputs_nonzero_cycles", 64'(nz), 64'd0);
    exp_q.delete();
    exp_q.push_back('0);
    prev_r0 = 1'b0;
  endtask

  // One full frame starting at its first cycle. mode 1: random input change
  // mid-frame, mode 2: assert master_mute mid-frame (after the mix completes).
  task automatic run_frame(input int mode);
    logic [32:0] cur;
    logic [31:0] obs;
    logic [8:0]  cc;
    logic        clip_mid;
    int          req_bad;
    int          clk_bad;
    int          clip_bad;
    req_bad  = 0;
    clk_bad  = 0;
    clip_bad = 0;
    obs      = '0;
    clip_mid = 1'b0;
    cur = exp_q.pop_front();
    exp_q.push_back(model_frame());
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      cc = 9'(c);
      if (sample_req !== (c == 0)) req_bad++;
      if (audio_mclk !== cc[1] || audio_sck !== cc[3] || audio_lrck !== cc[8]) clk_bad++;
      if (clip_flag !== cur[32]) clip_bad++;
      if (cc[3:0] == 4'd8) obs = {obs[30:0], audio_sdin};
      if (c == 256) clip_mid = clip_flag;
      if (c == 100) begin
        if (mode == 1) randomize_inputs();
        if (mode == 2) master_mute = 1'b1;
      end
    end
    check("sdin_stream", 64'(obs), 64'({prev_r0, cur[31:16], cur[15:1]}));
    check("clip_flag_mid", 64'(clip_mid), 64'(cur[32]));
    check("clip_flag_bad_cycles", 64'(clip_bad), 64'd0);
    check("sample_req_bad_cycles", 64'(req_bad), 64'd0);
    check("audio_clock_bad_cycles", 64'(clk_bad), 64'd0);
    prev_r0   = cur[0];
    last_obs  = obs;
    last_clip = clip_mid;
  endtask

  initial begin
    clear_inputs();
    apply_reset(5);
    run_frame(0);

    // Single voice, unity gain, left only.
    set_voice(0, 16'h1234, 1'b1, 4'd8, 2'b01);
    run_frame(0);
    clear_inputs();
    run_frame(0);
    check("t2_left_word", 64'(last_obs[30:15]), 64'h1234);
    check("t2_right_hi", 64'(last_obs[14:0]), 64'h0);

    // Full-scale sum clamps both sides, clip for that frame only.
    set_voice(0, 16'h7000, 1'b1, 4'd15, 2'b11);
    set_voice(1, 16'h7000, 1'b1, 4'd15, 2'b11);
    run_frame(0);
    clear_inputs();
    run_frame(0);
    check("t3_left_word", 64'(last_obs[30:15]), 64'h7FFF);
    check("t3_right_hi", 64'(last_obs[14:0]), 64'h3FFF);
    check("t3_clip_high", 64'(last_clip), 64'd1);
    run_frame(0);
    check("t3_clip_low_next", 64'(last_clip), 64'd0);
    check("t3_words_zero_next", 64'(last_obs[30:0]), 64'h0);

    // Negative plus positive voice, plus a silent gain-0 voice.
    set_voice(0, 16'hC000, 1'b1, 4'd8, 2'b01);
    set_voice(1, 16'h1000, 1'b1, 4'd4, 2'b01);
    set_voice(2, 16'h7FFF, 1'b1, 4'd0, 2'b01);
    run_frame(0);
    ch_valid[1] = 1'b0;
    run_frame(0);
    check("t4_mixed_word", 64'(last_obs[30:15]), 64'hC800);
    clear_inputs();
    run_frame(0);
    check("t4_invalid_voice_word", 64'(last_obs[30:15]), 64'hC000);

    // Mute after the mix does not touch the next frame; mute before does.
    set_voice(0, 16'h1234, 1'b1, 4'd8, 2'b11);
    run_frame(2);
    master_mute = 1'b1;
    run_frame(0);
    check("t5_late_mute_left", 64'(last_obs[30:15]), 64'h1234);
    check("t5_late_mute_right_hi", 64'(last_obs[14:0]), 64'h091A);
    master_mute = 1'b0;
    run_frame(0);
    check("t5_muted_words", 64'(last_obs[30:0]), 64'h0);

    // Reset in the middle of a frame discards pending words.
    clear_inputs();
    set_voice(0, 16'h5555, 1'b1, 4'd8, 2'b01);
    run_frame(0);
    repeat (300) @(negedge clk);
    apply_reset(10);
    clear_inputs();
    run_frame(0);
    check("t1_after_reset_stream", 64'(last_obs), 64'h0);

    // Random frames with mid-frame input churn.
    for (int f = 0; f < 100; f++) begin
      randomize_inputs();
      run_frame(1);
    end
    clear_inputs();
    run_frame(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
